// File: rtl/vga_scanout.sv
// 160x120x3 frame buffer scanned out as 640x480@60 VGA with 4x4 pixel replication.
// Define VGA_WRITE_CLIP_EN to drop writes whose (x,y) falls outside 160x120.
module vga_scanout #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       frame_start
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_DEPTH = 160 * 120;

  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        h_last;
  logic        v_last;

  logic [14:0] wr_addr;
  logic        wr_en;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data;
  logic [2:0]  fb_mem [FB_DEPTH];

  logic        hs_s1;
  logic        vs_s1;
  logic        blank_s1;

  // y*160 + x without a multiplier
  function automatic logic [14:0] fb_addr(input logic [7:0] col, input logic [6:0] row);
    logic [14:0] r;
    r = {8'b0, row};
    return (r << 7) + (r << 5) + {7'b0, col};
  endfunction

  assign h_last  = (hcount == H_LAST);
  assign v_last  = (vcount == V_LAST);
  assign wr_addr = fb_addr(x, y);

`ifdef VGA_WRITE_CLIP_EN
  assign wr_en = plot && (x < 8'd160) && (y < 7'd120);
`else
  assign wr_en = plot;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en      <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (h_last) begin
          hcount <= '0;
          if (v_last) begin
            vcount      <= '0;
            frame_start <= 1'b1;
          end else begin
            vcount <= vcount + 10'd1;
          end
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  // Stage 1: read address and sync/blank decode from the current counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr  <= '0;
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      blank_s1 <= 1'b1;
    end else if (pix_en) begin
      rd_addr  <= fb_addr(hcount[9:2], vcount[8:2]);
      hs_s1    <= !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
      vs_s1    <= !((vcount >= VS_FIRST) && (vcount <= VS_LAST));
      blank_s1 <= !((hcount < H_VIS_L) && (vcount < V_VIS_L));
    end
  end

  // Read sees the pre-write contents on a same-address collision
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fb_mem[wr_addr] <= colour;
    end
    rd_data <= fb_mem[rd_addr];
  end

  // Stage 2: registered pins, colour masked during blanking
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      vga_blank <= 1'b1;
      vga_r     <= 1'b0;
      vga_g     <= 1'b0;
      vga_b     <= 1'b0;
    end else if (pix_en) begin
      vga_hs    <= hs_s1;
      vga_vs    <= vs_s1;
      vga_blank <= blank_s1;
      {vga_r, vga_g, vga_b} <= blank_s1 ? 3'b000 : rd_data;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken raster (80x30 counts, 64x24 visible)
// so that several whole frames fit in a short run.
module tb_vga_scanout;

  // Line = 80 counts = 160 clk, frame = 30 lines = 4800 clk.
  localparam int H_VIS = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       plot = 1'b0;
  logic       vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b, frame_start;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [2:0] model [0:5][0:15];

  vga_scanout #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return vga_hs;
      1:       return vga_vs;
      2:       return vga_blank;
      default: return frame_start;
    endcase
  endfunction

  task automatic wait_level(input int sel, input logic val, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(sel) === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Measures low width and fall-to-fall period of an active-low signal.
  task automatic measure_low(input int sel, input string tag, input int exp_w, input int exp_p);
    logic ok;
    int t0, t1, t2;
    wait_level(sel, 1'b1, 6000, ok); check({tag, "_to_a"}, ok, 1);
    wait_level(sel, 1'b0, 6000, ok); check({tag, "_to_b"}, ok, 1);
    t0 = cyc;
    wait_level(sel, 1'b1, 6000, ok); check({tag, "_to_c"}, ok, 1);
    t1 = cyc;
    wait_level(sel, 1'b0, 6000, ok); check({tag, "_to_d"}, ok, 1);
    t2 = cyc;
    check({tag, "_width"}, t1 - t0, exp_w);
    check({tag, "_period"}, t2 - t0, exp_p);
  endtask

  task automatic put_px(input int px, input int py, input logic [2:0] c, input bit upd);
    @(negedge clk);
    x = 8'(px); y = 7'(py); colour = c; plot = 1'b1;
    @(negedge clk);
    plot = 1'b0;
    if (upd) model[py][px] = c;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hs"}, vga_hs, 1);
    check({tag, "_vs"}, vga_vs, 1);
    check({tag, "_blank"}, vga_blank, 1);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_fs"}, frame_start, 0);
  endtask

  initial begin
    logic ok;
    int t_rel, t0, t1, t2;

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    reset = 1'b0;
    t_rel = cyc;

    // Count n decoded at edge 2n+2, reaches the pins at edge 2n+4
    wait_level(2, 1'b0, 200, ok); check("first_blank_to", ok, 1);
    check("first_blank_at", cyc - t_rel, 4);
    wait_level(0, 1'b0, 400, ok); check("first_hs_to", ok, 1);
    check("first_hs_at", cyc - t_rel, 140);

    measure_low(0, "hs", 16, 160);
    measure_low(2, "blank", 128, 160);

    for (int yy = 0; yy < 6; yy++)
      for (int xx = 0; xx < 16; xx++)
        put_px(xx, yy, 3'b000, 1'b1);
    put_px(0, 0, 3'b100, 1'b1);
    put_px(1, 0, 3'b010, 1'b1);
    put_px(2, 2, 3'b011, 1'b1);
    put_px(14, 3, 3'b101, 1'b1);
    put_px(15, 5, 3'b111, 1'b1);
`ifdef VGA_WRITE_CLIP_EN
    // Would alias onto (0,1) if not discarded
    put_px(160, 0, 3'b111, 1'b0);
`endif

    // frame_start: first pulse one full frame after reset release
    wait_level(3, 1'b1, 6000, ok); check("fs_to_a", ok, 1);
    t0 = cyc;
    check("fs_first_at", t0 - t_rel, 4800);
    wait_level(3, 1'b0, 10, ok); check("fs_to_b", ok, 1);
    t1 = cyc;
    wait_level(3, 1'b1, 6000, ok); check("fs_to_c", ok, 1);
    t2 = cyc;
    check("fs_width", t1 - t0, 1);
    check("fs_period", t2 - t0, 4800);

    measure_low(1, "vs", 320, 4800);

    // Full-frame pixel probe: each stored pixel spans 8 clk horizontally, 4 lines vertically
    wait_level(3, 1'b1, 6000, ok); check("scan_fs_to", ok, 1);
    for (int ln = 0; ln < 24; ln++) begin
      wait_level(2, 1'b0, 400, ok);
      check($sformatf("line%0d_start", ln), ok, 1);
      for (int off = 0; off <= 128; off++) begin
        if (off > 0) @(negedge clk);
        if (off == 128) begin
          check($sformatf("line%0d_end_blank", ln), vga_blank, 1);
          check($sformatf("line%0d_end_rgb", ln), {vga_r, vga_g, vga_b}, 0);
        end else if (off == 0 || off == 7 || off == 8 || off == 15 || off == 16 ||
                     off == 119 || off == 120 || off == 127) begin
          check($sformatf("line%0d_off%0d_rgb", ln, off), {vga_r, vga_g, vga_b},
                model[ln / 4][off / 8]);
        end
      end
    end

    // Reset in the middle of vertical sync, then a clean restart
    repeat (400) @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle("midreset");
    end
    reset = 1'b0;
    t_rel = cyc;
    wait_level(2, 1'b0, 200, ok); check("re_blank_to", ok, 1);
    check("re_blank_at", cyc - t_rel, 4);
    check("re_vs_idle", vga_vs, 1);
    wait_level(0, 1'b0, 400, ok); check("re_hs_to", ok, 1);
    check("re_hs_at", cyc - t_rel, 140);
    wait_level(3, 1'b1, 6000, ok); check("re_fs_to", ok, 1);
    check("re_fs_at", cyc - t_rel, 4800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
